// File: rtl/cache_refill_controller_pkg.sv
// Shared types and constants for the cache refill controller and its stats counters.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        REFILL,
        WT_REQ,
        RESP
    } cache_state_t;

    // Default geometry, matching the controller's default parameters
    localparam int DEF_ADDR_SIZE       = 32;
    localparam int DEF_NUM_SETS        = 16;
    localparam int DEF_WORDS_PER_BLOCK = 4;

    // Each word is 32 bits, so two byte-offset bits sit below the word index
    localparam int BYTE_OFF_W  = 2;
    localparam int DEF_WORD_W  = $clog2(DEF_WORDS_PER_BLOCK);
    localparam int DEF_SET_W   = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W   = DEF_ADDR_SIZE - DEF_SET_W - DEF_WORD_W - BYTE_OFF_W;

    // Address split as seen by the datapath decode (default geometry)
    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_SET_W-1:0]  set;
        logic [DEF_WORD_W-1:0] word;
        logic [BYTE_OFF_W-1:0] byte_off;
    } cache_addr_t;

    // Statistics counters stick at this value instead of wrapping
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    // Number of low address bits cleared to form a block-aligned address
    function automatic int block_off_w(input int words_per_block);
        return $clog2(words_per_block) + BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/cache_refill_controller_stats_counter.sv
// Saturating 32-bit event counter with synchronous clear.
// Latency: count reflects an inc one cycle after it is asserted.
// Backpressure: none; inc is never stalled, the count simply holds at STAT_MAX.
module cache_stats_counter
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] count_q;

    // Count events, holding at the maximum rather than wrapping to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != STAT_MAX)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_refill_controller.sv
// Sequences one CPU load/store through tag lookup, block refill on read miss, and write-through; optional hit/miss statistics under CACHE_REFILL_STATS_EN.
// Latency: load hit resp 2 cycles after the handshake cycle, store 3 + memory accept wait, load miss 4 + memory accept wait + refill cycles.
// Backpressure: cpu_req_ready only in IDLE; memory requests held stable until mem_req_ready; refill beats may arrive with gaps.
module cache_refill_controller
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE       = 32,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 4,
    parameter int WORDS_PER_BLOCK = 4
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cpu_req_valid,
    input  logic                               cpu_req_write,
    input  logic [ADDR_SIZE-1:0]               cpu_req_addr,
    output logic                               cpu_req_ready,
    output logic                               cpu_resp_valid,
    output logic [ADDR_SIZE-1:0]               lookup_addr,
    input  logic                               cache_hit,
    output logic                               cache_write_en,
    output logic                               fill_en,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               fill_last,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic                               mem_req_write,
    output logic [ADDR_SIZE-1:0]               mem_req_addr,
    input  logic                               mem_rdata_valid,
    output logic [31:0]                        hit_count,
    output logic [31:0]                        miss_count
);

    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_W  = block_off_w(WORDS_PER_BLOCK);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

    // Reject geometries the word counter and block alignment cannot represent
    if (((NUM_SETS & (NUM_SETS - 1)) != 0) || ((NUM_WAYS & (NUM_WAYS - 1)) != 0) ||
        ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) || (WORDS_PER_BLOCK < 2)) begin : g_bad_geometry
        $error("cache_refill_controller: NUM_SETS, NUM_WAYS, WORDS_PER_BLOCK must be powers of 2, WORDS_PER_BLOCK >= 2");
    end

    cache_state_t      state;
    cache_state_t      state_nxt;
    logic              req_write;
    logic [WORD_W-1:0] word_cnt;
    logic              req_fire;
    logic              beat_fire;

    assign req_fire  = (state == IDLE) && cpu_req_valid;
    assign beat_fire = (state == REFILL) && mem_rdata_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the request on handshake; it stays frozen until the next IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_addr <= '0;
            req_write   <= 1'b0;
        end else if (req_fire) begin
            lookup_addr <= cpu_req_addr;
            req_write   <= cpu_req_write;
        end
    end

    // Refill word index: cleared when the block read is accepted, stepped per beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if ((state == MEM_REQ) && mem_req_ready) begin
            word_cnt <= '0;
        end else if (beat_fire) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt      = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cache_write_en = 1'b0;
        fill_en        = 1'b0;
        fill_word      = word_cnt;
        fill_last      = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_write  = 1'b0;
        mem_req_addr   = lookup_addr;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_write) begin
                    // Write-through, no-write-allocate: update the array only on a hit
                    cache_write_en = cache_hit;
                    state_nxt      = WT_REQ;
                end else if (cache_hit) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {lookup_addr[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_req_ready) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (mem_rdata_valid) begin
                    fill_en = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        // Final beat: datapath sets valid+tag, then we look up again
                        fill_last = 1'b1;
                        state_nxt = LOOKUP;
                    end
                end
            end
            WT_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef CACHE_REFILL_STATS_EN
    logic relookup;
    logic first_lookup;

    // Marks the lookup that follows a completed refill so it is not counted twice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            relookup <= 1'b0;
        end else if (beat_fire && (word_cnt == LAST_WORD)) begin
            relookup <= 1'b1;
        end else if (state == IDLE) begin
            relookup <= 1'b0;
        end
    end

    assign first_lookup = (state == LOOKUP) && !relookup;

    cache_stats_counter u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (first_lookup && cache_hit),
        .clr   (1'b0),
        .count (hit_count)
    );

    cache_stats_counter u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (first_lookup && !cache_hit),
        .clr   (1'b0),
        .count (miss_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Randomized self-checking bench for cache_refill_controller against a transaction-level cache/memory model.
// Latency: n/a (testbench).
// Backpressure: memory accept delay and refill beat gaps are varied per transaction.
module tb_cache_refill_controller;

    localparam int WPB = 4;
`ifdef CACHE_REFILL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_write;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] lookup_addr;
    logic        cache_hit;
    logic        cache_write_en;
    logic        fill_en;
    logic [1:0]  fill_word;
    logic        fill_last;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic        mem_rdata_valid;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Model: blocks currently resident in the cache, keyed by block number
    bit          resident [logic [27:0]];
    logic [31:0] exp_hits   = '0;
    logic [31:0] exp_misses = '0;

    always #5 clk = ~clk;

    cache_refill_controller dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_write   (cpu_req_write),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_resp_valid  (cpu_resp_valid),
        .lookup_addr     (lookup_addr),
        .cache_hit       (cache_hit),
        .cache_write_en  (cache_write_en),
        .fill_en         (fill_en),
        .fill_word       (fill_word),
        .fill_last       (fill_last),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_rdata_valid (mem_rdata_valid),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    // One full CPU transaction; gap < 0 picks a random gap before each beat
    task automatic do_txn(input bit wr, input logic [31:0] addr, input int wait_cyc,
                          input int gap, input bit hold);
        bit          exp_hit;
        logic [31:0] exp_maddr;
        int          cyc = 0, resp_cyc = -1, mem_first = -1, last_beat = -1;
        int          wcnt = 0, n_mem_hs = 0, n_we = 0, n_last = 0, last_at = -1;
        int          beats = 0, gap_left = 0, exp_resp, exp_mem_hs, exp_fills;
        bit          in_refill = 0, mem_bad = 0, ready_bad = 0, lookup_bad = 0, seq_bad = 0, done = 0;
        int          fills [$];

        exp_hit   = resident.exists(addr[31:4]);
        exp_maddr = wr ? addr : {addr[31:4], 4'h0};
        cache_hit = exp_hit;
        @(negedge clk);
        n_checks++;
        if (cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: got %b, expected 1", cpu_req_ready);
        end
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = addr;
        @(posedge clk);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                cpu_req_valid = 1'($urandom_range(0, 1));
                cpu_req_write = 1'($urandom_range(0, 1));
                cpu_req_addr  = $urandom;
            end
            if (cpu_req_ready !== 1'b0) ready_bad = 1;
            if (lookup_addr !== addr) lookup_bad = 1;
            mem_req_ready   = 1'b0;
            mem_rdata_valid = 1'b0;
            if (mem_req_valid === 1'b1) begin
                if (mem_first < 0) mem_first = cyc;
                if (mem_req_addr !== exp_maddr || mem_req_write !== wr) mem_bad = 1;
                if (wcnt == wait_cyc) begin
                    mem_req_ready = 1'b1;
                    n_mem_hs++;
                    // A beat coincident with the read handshake must be ignored
                    if (!wr) mem_rdata_valid = 1'($urandom_range(0, 1));
                end else begin
                    wcnt++;
                end
            end else if (in_refill && beats < WPB) begin
                if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    mem_rdata_valid = 1'b1;
                    beats++;
                    gap_left = (gap < 0) ? $urandom_range(0, 2) : gap;
                    if (beats == WPB) begin
                        last_beat = cyc;
                        resident[addr[31:4]] = 1'b1;
                        cache_hit = 1'b1;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_rdata_valid = 1'b1;
            end
            #1;
            if (cache_write_en === 1'b1) n_we++;
            if (fill_en === 1'b1) begin
                fills.push_back(int'(fill_word));
                if (fill_last === 1'b1) begin
                    n_last++;
                    last_at = fills.size();
                end
            end else if (fill_last === 1'b1) begin
                n_last++;
            end
            if (mem_req_ready && mem_req_valid === 1'b1 && !wr) in_refill = 1;
            if (cpu_resp_valid === 1'b1) begin
                resp_cyc = cyc;
                done     = 1;
            end
        end
        cpu_req_valid   = hold;
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;

        // Expectations from the request kind and the stimulus timing
        exp_mem_hs = (!wr && exp_hit) ? 0 : 1;
        exp_fills  = (!wr && !exp_hit) ? WPB : 0;
        if (!wr && exp_hit)  exp_resp = 2;
        else if (wr)         exp_resp = 3 + wait_cyc;
        else                 exp_resp = last_beat + 2;
        if (STATS) begin
            if (exp_hit) begin
                if (exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 1;
            end else begin
                if (exp_misses != 32'hFFFF_FFFF) exp_misses = exp_misses + 1;
            end
        end
        for (int i = 0; i < fills.size(); i++) if (fills[i] != i) seq_bad = 1;

        n_checks++;
        if (resp_cyc != exp_resp) begin
            n_fail++;
            $display("FAIL resp_latency addr=%h wr=%0d: got %0d, expected %0d", addr, wr, resp_cyc, exp_resp);
        end
        n_checks++;
        if (n_mem_hs != exp_mem_hs) begin
            n_fail++;
            $display("FAIL mem_req_count addr=%h: got %0d, expected %0d", addr, n_mem_hs, exp_mem_hs);
        end
        n_checks++;
        if (mem_first != (exp_mem_hs ? 2 : -1)) begin
            n_fail++;
            $display("FAIL mem_req_start addr=%h: got %0d, expected %0d", addr, mem_first, exp_mem_hs ? 2 : -1);
        end
        n_checks++;
        if (mem_bad) begin
            n_fail++;
            $display("FAIL mem_req_fields addr=%h: got addr %h write %b, expected addr %h write %b",
                     addr, mem_req_addr, mem_req_write, exp_maddr, wr);
        end
        n_checks++;
        if (n_we != int'(wr && exp_hit)) begin
            n_fail++;
            $display("FAIL cache_write_en addr=%h: got %0d pulses, expected %0d", addr, n_we, int'(wr && exp_hit));
        end
        n_checks++;
        if (fills.size() != exp_fills || seq_bad) begin
            n_fail++;
            $display("FAIL fill_words addr=%h: got %0d beats (order ok=%0d), expected %0d in order",
                     addr, fills.size(), !seq_bad, exp_fills);
        end
        n_checks++;
        if (n_last != (exp_fills ? 1 : 0) || (exp_fills && last_at != WPB)) begin
            n_fail++;
            $display("FAIL fill_last addr=%h: got %0d at beat %0d, expected %0d at beat %0d",
                     addr, n_last, last_at, exp_fills ? 1 : 0, WPB);
        end
        n_checks++;
        if (ready_bad || lookup_bad) begin
            n_fail++;
            $display("FAIL busy_window addr=%h: got ready_leak=%0d addr_change=%0d, expected 0 0", addr, ready_bad, lookup_bad);
        end
        n_checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            n_fail++;
            $display("FAIL stats addr=%h: got hit %h miss %h, expected hit %h miss %h",
                     addr, hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = '0;
        cache_hit = 0; mem_req_ready = 0; mem_rdata_valid = 0;
        #12;
        n_checks++;
        if ({cpu_resp_valid, cache_write_en, fill_en, fill_last, mem_req_valid, mem_req_write} !== 6'b0 ||
            cpu_req_ready !== 1'b1 || lookup_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got strobes %b ready %b addr %h, expected 000000 1 00000000",
                     {cpu_resp_valid, cache_write_en, fill_en, fill_last, mem_req_valid, mem_req_write},
                     cpu_req_ready, lookup_addr);
        end
        n_checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h %h, expected 0 0", hit_count, miss_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_hit();
        resident[28'h000_0004] = 1'b1;
        do_txn(1'b0, 32'h0000_0040, 0, 0, 1'b0);
    endtask

    task automatic test_load_miss();
        do_txn(1'b0, 32'h0000_1234, 0, 1, 1'b0);
    endtask

    task automatic test_store_hit_slow_mem();
        resident[28'h000_0010] = 1'b1;
        do_txn(1'b1, 32'h0000_0100, 5, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 32'h2000_0008, 1, 0, 1'b1);
        do_txn(1'b0, 32'h0000_0044, 0, 0, 1'b0);
    endtask

    task automatic test_stats_saturation();
`ifdef CACHE_REFILL_STATS_EN
        @(negedge clk);
        force dut.u_hit_cnt.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_hit_cnt.count_q;
        exp_hits = 32'hFFFF_FFFF;
`endif
        do_txn(1'b0, 32'h0000_0048, 0, 0, 1'b0);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            do_txn($urandom_range(0, 2) == 0, 32'h0000_3000 + 32'($urandom_range(0, 255)),
                   $urandom_range(0, 3), -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_refill();
        int  t = 0;
        bit  saw_fill = 0;
        cache_hit = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 32'h0000_5678;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        while (mem_req_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (mem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_start: got mem_req_valid %b, expected 1", mem_req_valid);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rdata_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cpu_resp_valid, cache_write_en, fill_en, fill_last, mem_req_valid, mem_req_write} !== 6'b0 ||
            cpu_req_ready !== 1'b1 || lookup_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_refill: got strobes %b ready %b addr %h, expected 000000 1 00000000",
                     {cpu_resp_valid, cache_write_en, fill_en, fill_last, mem_req_valid, mem_req_write},
                     cpu_req_ready, lookup_addr);
        end
        mem_rdata_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (fill_en !== 1'b0 || fill_last !== 1'b0) saw_fill = 1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (fill_en !== 1'b0 || fill_last !== 1'b0) saw_fill = 1;
        end
        mem_rdata_valid = 1'b0;
        n_checks++;
        if (saw_fill) begin
            n_fail++;
            $display("FAIL abandoned_refill: got fill strobe after reset, expected none");
        end
        exp_hits   = '0;
        exp_misses = '0;
        // Abandoned block is not resident; a fresh miss must refill from word 0
        do_txn(1'b0, 32'h0000_5678, 2, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_load_miss();
        test_store_hit_slow_mem();
        test_back_to_back();
        test_stats_saturation();
        test_random(24);
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
